// File: rtl/usb_audio_pkg.sv
// Shared types and frame-format helpers for the USB audio input path.
package usb_audio_pkg;

  // Read-sequencer states for the FT245-style FIFO reader.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STROBE  = 2'd1,
    RECOVER = 2'd2,
    HOLD    = 2'd3
  } rd_state_t;

  localparam int unsigned MAX_BYTES_PER_SAMPLE = 4;
  localparam int unsigned SAMPLE_W             = 32;

  // raw holds the sample bytes LSB-first in its low bytes; the result is
  // left-justified in SAMPLE_W bits with zero-padded LSBs.
  function automatic logic [SAMPLE_W-1:0] pack_sample(
    input logic [SAMPLE_W-1:0] raw,
    input int unsigned         bps
  );
    logic [SAMPLE_W-1:0] masked;
    masked = '0;
    for (int unsigned i = 0; i < MAX_BYTES_PER_SAMPLE; i++) begin
      if (i < bps) masked[8*i +: 8] = raw[8*i +: 8];
    end
    return masked << (8 * (MAX_BYTES_PER_SAMPLE - bps));
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous status pin.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usb_fifo_reader.sv
// Pulls PCM bytes from an FT245-style FIFO and assembles stereo frames
// with a valid/ready output register and read backpressure.
module usb_fifo_reader
  import usb_audio_pkg::*;
#(
  parameter int unsigned BYTES_PER_SAMPLE = 2,
  parameter int unsigned RD_LOW_CYCLES    = 4,
  parameter int unsigned RD_HIGH_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  fifo_data,
  input  logic        fifo_rxf_n,
  output logic        fifo_rd_n,
  input  logic        flush,
  output logic [31:0] sample_left,
  output logic [31:0] sample_right,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        partial
);

  localparam int unsigned FRAME_BYTES = 2 * BYTES_PER_SAMPLE;
  localparam int unsigned IDX_W       = $clog2(FRAME_BYTES);
  localparam int unsigned CNT_MAX     = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ?
                                        RD_LOW_CYCLES : RD_HIGH_CYCLES;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_BYTES - 1);
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RD_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(RD_HIGH_CYCLES - 1);

  logic                rxf_s;
  rd_state_t           state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [IDX_W-1:0]    byte_idx, byte_idx_nxt;
  logic                rd_n_q, rd_n_nxt;
  logic                drop_q, drop_nxt;
  logic                capture;
  logic                load;
  logic                output_free;
  logic [7:0]          byte_buf [FRAME_BYTES];
  logic [SAMPLE_W-1:0] left_raw, right_raw;

  sync_2ff #(.RESET_VAL(1'b1)) u_rxf_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (fifo_rxf_n),
    .q    (rxf_s)
  );

  assign output_free = !sample_valid || sample_ready;
  assign fifo_rd_n   = rd_n_q;
  assign partial     = (byte_idx != '0) || (state == HOLD);

  // Next-state, strobe and buffer-control decode for the read sequencer.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    byte_idx_nxt = byte_idx;
    rd_n_nxt     = rd_n_q;
    drop_nxt     = drop_q;
    capture      = 1'b0;
    load         = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush) begin
          byte_idx_nxt = '0;
        end else if (!rxf_s) begin
          state_nxt = STROBE;
          rd_n_nxt  = 1'b0;
          cnt_nxt   = '0;
        end
      end
      STROBE: begin
        // A flush during the pulse is remembered so the pulse still runs to
        // full width; the flag then carries through RECOVER so that exit
        // does not advance byte_idx past the discarded byte.
        drop_nxt = drop_q | flush;
        if (cnt == LOW_LAST) begin
          rd_n_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RECOVER;
          if (drop_q || flush) byte_idx_nxt = '0;
          else                 capture      = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RECOVER: begin
        if (flush) begin
          state_nxt    = IDLE;
          byte_idx_nxt = '0;
          drop_nxt     = 1'b0;
          cnt_nxt      = '0;
        end else if (cnt == HIGH_LAST) begin
          cnt_nxt  = '0;
          drop_nxt = 1'b0;
          if (drop_q) begin
            state_nxt = IDLE;
          end else if (byte_idx != LAST_IDX) begin
            byte_idx_nxt = byte_idx + 1'b1;
            state_nxt    = IDLE;
          end else if (output_free) begin
            load         = 1'b1;
            byte_idx_nxt = '0;
            state_nxt    = IDLE;
          end else begin
            state_nxt = HOLD;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          state_nxt    = IDLE;
          byte_idx_nxt = '0;
        end else if (output_free) begin
          load         = 1'b1;
          byte_idx_nxt = '0;
          state_nxt    = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Sequencer state register; reset drives the read strobe high at once.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      cnt      <= '0;
      byte_idx <= '0;
      rd_n_q   <= 1'b1;
      drop_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      byte_idx <= byte_idx_nxt;
      rd_n_q   <= rd_n_nxt;
      drop_q   <= drop_nxt;
    end
  end

  // Byte buffer: capture the bus on the edge where the strobe rises.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < FRAME_BYTES; i++) byte_buf[i] <= '0;
    end else if (capture) begin
      byte_buf[byte_idx] <= fifo_data;
    end
  end

  // Gather each channel's bytes LSB-first ahead of left-justification.
  always_comb begin
    left_raw  = '0;
    right_raw = '0;
    for (int unsigned i = 0; i < BYTES_PER_SAMPLE; i++) begin
      left_raw[8*i +: 8]  = byte_buf[i];
      right_raw[8*i +: 8] = byte_buf[BYTES_PER_SAMPLE + i];
    end
  end

  // Output register: a load wins over a same-cycle accept, keeping valid high.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
    end else if (load) begin
      sample_left  <= pack_sample(left_raw, BYTES_PER_SAMPLE);
      sample_right <= pack_sample(right_raw, BYTES_PER_SAMPLE);
      sample_valid <= 1'b1;
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_fifo_reader.sv
// Self-checking bench for usb_fifo_reader: FIFO behavioural model,
// frame scoreboard, strobe timing monitor and directed/random steps.
module tb_usb_fifo_reader;

  localparam int B  = 2;
  localparam int L  = 4;
  localparam int H  = 4;
  localparam int TP = 10;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        flush = 1'b0;
  logic        sample_ready = 1'b0;
  logic [7:0]  fifo_data;
  logic        fifo_rxf_n;
  logic        fifo_rd_n;
  logic [31:0] sample_left, sample_right;
  logic        sample_valid, partial;

  logic        ready3 = 1'b0;
  logic [7:0]  fifo_data3;
  logic        fifo_rxf3_n;
  logic        fifo_rd3_n;
  logic [31:0] left3, right3;
  logic        valid3, partial3;

  int checks = 0;
  int errors = 0;

  always #(TP/2) clk = ~clk;

  usb_fifo_reader #(
    .BYTES_PER_SAMPLE(2),
    .RD_LOW_CYCLES   (4),
    .RD_HIGH_CYCLES  (4)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .fifo_data    (fifo_data),
    .fifo_rxf_n   (fifo_rxf_n),
    .fifo_rd_n    (fifo_rd_n),
    .flush        (flush),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .partial      (partial)
  );

  usb_fifo_reader #(
    .BYTES_PER_SAMPLE(3),
    .RD_LOW_CYCLES   (4),
    .RD_HIGH_CYCLES  (4)
  ) dut3 (
    .clk          (clk),
    .nrst         (nrst),
    .fifo_data    (fifo_data3),
    .fifo_rxf_n   (fifo_rxf3_n),
    .fifo_rd_n    (fifo_rd3_n),
    .flush        (1'b0),
    .sample_left  (left3),
    .sample_right (right3),
    .sample_valid (valid3),
    .sample_ready (ready3),
    .partial      (partial3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- FIFO model (B=2 device) ----------------
  logic [7:0]  fifo_q[$];
  int          fifo_cnt = 0;
  logic [7:0]  fifo_front = 8'h00;
  bit          fifo_en = 1'b0;

  assign fifo_rxf_n = !(fifo_en && fifo_cnt != 0);
  assign fifo_data  = fifo_front;

  function automatic void fifo_sync();
    fifo_cnt   = fifo_q.size();
    fifo_front = (fifo_cnt != 0) ? fifo_q[0] : 8'h00;
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_sync();
  endtask

  // ---------------- Frame reference model ----------------
  logic [7:0]  acc[$];
  logic [31:0] exp_l[$];
  logic [31:0] exp_r[$];
  bit          drop_next = 1'b0;

  function automatic void accept_byte(input logic [7:0] b);
    logic [31:0] l = 0;
    logic [31:0] r = 0;
    if (drop_next) begin
      drop_next = 1'b0;
      return;
    end
    acc.push_back(b);
    if (acc.size() == 2*B) begin
      for (int i = 0; i < B; i++) begin
        l = l + (32'(acc[i]) << (8*i));
        r = r + (32'(acc[B+i]) << (8*i));
      end
      exp_l.push_back(l << (8*(4-B)));
      exp_r.push_back(r << (8*(4-B)));
      acc.delete();
    end
  endfunction

  // ---------------- Strobe monitor ----------------
  int  pulses = 0;
  time t_fall = 0;
  time t_rise_last = 0;
  bit  rise_valid = 1'b0;

  always begin
    @(negedge fifo_rd_n);
    t_fall = $time;
    chk("rd_while_empty", fifo_cnt != 0, 1'b1);
    if (rise_valid) chk("rd_high_gap", (t_fall - t_rise_last) >= H*TP, 1'b1);
    @(posedge fifo_rd_n);
    if (nrst) begin
      chk("rd_low_width", 32'((($time - t_fall) / TP)), L);
      t_rise_last = $time;
      rise_valid  = 1'b1;
    end
    if (fifo_cnt != 0) begin
      logic [7:0] b;
      b = fifo_q.pop_front();
      fifo_sync();
      accept_byte(b);
    end
    pulses++;
  end

  // ---------------- Output scoreboard ----------------
  int accepted = 0;

  always @(negedge clk) begin
    if (nrst && sample_valid && sample_ready) begin
      chk("frame_expected", exp_l.size() != 0, 1'b1);
      if (exp_l.size() != 0) begin
        chk("sb_left", sample_left, exp_l.pop_front());
        chk("sb_right", sample_right, exp_r.pop_front());
      end
      accepted++;
    end
  end

  // ---------------- FIFO model (B=3 device) ----------------
  logic [7:0] q3[$];
  int         cnt3 = 0;
  logic [7:0] front3 = 8'h00;

  assign fifo_rxf3_n = (cnt3 == 0);
  assign fifo_data3  = front3;

  function automatic void sync3();
    cnt3   = q3.size();
    front3 = (cnt3 != 0) ? q3[0] : 8'h00;
  endfunction

  always begin
    @(negedge fifo_rd3_n);
    @(posedge fifo_rd3_n);
    if (q3.size() != 0) void'(q3.pop_front());
    sync3();
  end

  // ---------------- Helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (sample_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk(tag, sample_valid, 1'b1);
  endtask

  task automatic wait_rd_low(input string tag, input int budget);
    int n = 0;
    while (fifo_rd_n !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, fifo_rd_n, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- Directed + random sequence ----------------
  initial begin
    int p0;
    int n;
    int a0;
    logic [7:0] nb[6];

    // Reset state
    step(5);
    nrst = 1'b1;
    chk("rst_rd_n", fifo_rd_n, 1'b1);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_left", sample_left, 32'h0);
    chk("rst_right", sample_right, 32'h0);
    chk("rst_partial", partial, 1'b0);
    p0 = pulses;
    step(100);
    chk("rst_no_rd", pulses - p0, 0);

    // Single B=2 frame, ready high
    sample_ready = 1'b1;
    p0 = pulses;
    push(8'h34); push(8'h12); push(8'h78); push(8'h56);
    fifo_en = 1'b1;
    n = 0;
    while (fifo_rd_n !== 1'b0 && n < 10) begin
      step();
      n++;
    end
    chk("rxf_to_rd_latency", n, 3);
    wait_valid("t1_valid", 100);
    chk("t1_left", sample_left, 32'h1234_0000);
    chk("t1_right", sample_right, 32'h5678_0000);
    step();
    chk("t1_valid_one_cycle", sample_valid, 1'b0);
    chk("t1_pulses", pulses - p0, 4);

    // B=3 frame on the second instance
    ready3 = 1'b1;
    q3.push_back(8'h56); q3.push_back(8'h34); q3.push_back(8'h12);
    q3.push_back(8'hBC); q3.push_back(8'h9A); q3.push_back(8'h78);
    sync3();
    n = 0;
    while (valid3 !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("b3_valid", valid3, 1'b1);
    chk("b3_left", left3, 32'h1234_5600);
    chk("b3_right", right3, 32'h789A_BC00);

    // Backpressure: two frames with ready low, second waits in HOLD
    sample_ready = 1'b0;
    p0 = pulses;
    for (int i = 0; i < 10; i++) push(8'($urandom));
    step(250);
    chk("bp_valid", sample_valid, 1'b1);
    chk("bp_partial_hold", partial, 1'b1);
    chk("bp_rd_idle", fifo_rd_n, 1'b1);
    chk("bp_pulses", pulses - p0, 8);
    chk("bp_fifo_left", fifo_cnt, 2);
    chk("bp_first_left", sample_left, exp_l[0]);
    chk("bp_first_right", sample_right, exp_r[0]);
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    chk("bp_reload_valid", sample_valid, 1'b1);
    chk("bp_second_left", sample_left, exp_l[0]);
    chk("bp_second_right", sample_right, exp_r[0]);
    step(60);
    chk("bp_resume_pulses", pulses - p0, 10);
    chk("bp_resume_partial", partial, 1'b1);
    push(8'($urandom)); push(8'($urandom));
    sample_ready = 1'b1;
    n = 0;
    while ((exp_l.size() != 0 || sample_valid || acc.size() != 0) && n < 300) begin
      step();
      n++;
    end
    chk("bp_drain", exp_l.size(), 0);

    // RXF# goes high after 3 bytes, then data returns
    p0 = pulses;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    step(80);
    chk("gap_pulses", pulses - p0, 3);
    chk("gap_partial", partial, 1'b1);
    chk("gap_rd_idle", fifo_rd_n, 1'b1);
    chk("gap_no_valid", sample_valid, 1'b0);
    push(8'($urandom));
    wait_valid("gap_valid", 100);
    step();
    chk("gap_drain", exp_l.size(), 0);

    // flush after one byte; new frame built from new bytes only
    push(8'($urandom));
    step(30);
    chk("fl_partial_before", partial, 1'b1);
    flush = 1'b1;
    acc.delete();
    step();
    flush = 1'b0;
    chk("fl_partial_after", partial, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nb[i] = 8'($urandom);
      push(nb[i]);
    end
    wait_valid("fl_valid", 100);
    chk("fl_left", sample_left, {nb[1], nb[0], 16'h0});
    chk("fl_right", sample_right, {nb[3], nb[2], 16'h0});
    step(2);

    // Randomised traffic: random ready and RXF# availability
    a0 = accepted;
    for (int i = 0; i < 20*2*B; i++) push(8'($urandom));
    n = 0;
    while ((exp_l.size() != 0 || fifo_cnt != 0 || acc.size() != 0 || sample_valid) && n < 6000) begin
      sample_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) fifo_en = ~fifo_en;
      if (fifo_cnt != 0 && !fifo_en && $urandom_range(0, 3) == 0) fifo_en = 1'b1;
      step();
      n++;
    end
    fifo_en = 1'b1;
    sample_ready = 1'b1;
    chk("rnd_accepted", accepted - a0, 20);
    chk("rnd_fifo_empty", fifo_cnt, 0);
    step(5);

    // flush during STROBE: pulse completes, that byte is discarded
    for (int i = 0; i < 5; i++) begin
      nb[i] = 8'($urandom);
      push(nb[i]);
    end
    wait_rd_low("fs_rd_low", 50);
    flush = 1'b1;
    acc.delete();
    drop_next = 1'b1;
    step();
    flush = 1'b0;
    chk("fs_still_low", fifo_rd_n, 1'b0);
    wait_valid("fs_valid", 200);
    chk("fs_left", sample_left, {nb[2], nb[1], 16'h0});
    chk("fs_right", sample_right, {nb[4], nb[3], 16'h0});
    step(2);

    // nrst asserted mid-STROBE with a frame pending in the output
    sample_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'($urandom));
    wait_valid("rs_valid", 100);
    wait_rd_low("rs_rd_low", 50);
    #3;
    nrst = 1'b0;
    #1;
    chk("rs_rd_high", fifo_rd_n, 1'b1);
    chk("rs_valid_clear", sample_valid, 1'b0);
    chk("rs_partial", partial, 1'b0);
    chk("rs_left", sample_left, 32'h0);
    fifo_en = 1'b0;
    fifo_q.delete();
    fifo_sync();
    acc.delete();
    exp_l.delete();
    exp_r.delete();
    drop_next = 1'b0;
    rise_valid = 1'b0;
    step(2);
    nrst = 1'b1;
    sample_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'($urandom));
    fifo_en = 1'b1;
    wait_valid("post_rst_valid", 100);
    step(2);
    chk("post_rst_drain", exp_l.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
